// File: rtl/serial_link_obi_watchdog.sv
// -----------------------------------------------------------------------------
// serial_link_obi_watchdog
//
// OBI-to-OBI stage in front of the serial link wrapper's OBI slave port. While
// the link answers, requests and responses pass through combinationally and the
// number of forwarded transactions awaiting rvalid is capped. If the link stays
// silent for TimeoutCycles cycles with work outstanding, every outstanding
// transaction is answered locally with an error (DRAIN). New requests are then
// failed fast (BLOCKED) until every abandoned response has come back late and
// been swallowed, so a late response is never paired with a newer request.
//
// Handshake semantics: a request transfers on a cycle where req and gnt are
// both high; a response is a single-cycle rvalid pulse with rdata/err valid in
// that same cycle; OBI responses return in request order.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   slv_req_i/slv_gnt_o                request handshake from the system bus
//   slv_addr_i/we_i/be_i/wdata_i       request payload
//   slv_rvalid_o/rdata_o/err_o         response to the system bus
//   mst_req_o/mst_gnt_i                request handshake toward the link
//   mst_addr_o/we_o/be_o/wdata_o       forwarded payload (pure wires)
//   mst_rvalid_i/mst_rdata_i           response from the link
//   clear_i                            software recovery, zeroes the stale count
//   timeout_o                          one-cycle pulse on the first DRAIN cycle
//   blocked_o                          high in DRAIN or BLOCKED
//   stale_o                            abandoned transactions still in flight
// -----------------------------------------------------------------------------
module serial_link_obi_watchdog #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024,
    parameter logic [31:0] ErrRdata       = 32'hBADCAB1E
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  slv_req_i,
    output logic                                  slv_gnt_o,
    input  logic [31:0]                           slv_addr_i,
    input  logic                                  slv_we_i,
    input  logic [3:0]                            slv_be_i,
    input  logic [31:0]                           slv_wdata_i,
    output logic                                  slv_rvalid_o,
    output logic [31:0]                           slv_rdata_o,
    output logic                                  slv_err_o,
    output logic                                  mst_req_o,
    input  logic                                  mst_gnt_i,
    output logic [31:0]                           mst_addr_o,
    output logic                                  mst_we_o,
    output logic [3:0]                            mst_be_o,
    output logic [31:0]                           mst_wdata_o,
    input  logic                                  mst_rvalid_i,
    input  logic [31:0]                           mst_rdata_i,
    input  logic                                  clear_i,
    output logic                                  timeout_o,
    output logic                                  blocked_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   stale_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned WdW  = $clog2(TimeoutCycles + 1);

    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [WdW-1:0]  WdLast  = WdW'(TimeoutCycles - 1);
    localparam logic [WdW-1:0]  WdOne   = WdW'(1);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] stale_q, stale_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic            err_pend_q, err_pend_d;
    logic            timeout_q, timeout_d;

    logic            below_max;
    logic            timeout_hit;
    logic            handshake;
    logic [CntW-1:0] stale_next;

    // Payload is never registered or altered.
    assign mst_addr_o  = slv_addr_i;
    assign mst_we_o    = slv_we_i;
    assign mst_be_o    = slv_be_i;
    assign mst_wdata_o = slv_wdata_i;

    assign timeout_o = timeout_q;
    assign blocked_o = (state_q != ST_ACTIVE);
    assign stale_o   = stale_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stale_d      = stale_q;
        wd_d         = '0;
        err_pend_d   = 1'b0;
        timeout_d    = 1'b0;

        mst_req_o    = 1'b0;
        slv_gnt_o    = 1'b0;
        slv_rvalid_o = 1'b0;
        slv_err_o    = 1'b0;
        slv_rdata_o  = mst_rdata_i;

        below_max    = (cnt_q < CntMax);
        timeout_hit  = 1'b0;
        handshake    = 1'b0;

        // Outside ACTIVE every late response retires one abandoned transaction;
        // a response with nothing abandoned is ignored. clear_i wins over that.
        stale_next = stale_q;
        if (mst_rvalid_i && (stale_q != '0)) begin
            stale_next = stale_q - CntOne;
        end
        if (clear_i) begin
            stale_next = '0;
        end

        unique case (state_q)
            ST_ACTIVE: begin
                timeout_hit  = (wd_q == WdLast) && (cnt_q != '0) && !mst_rvalid_i;
                // No new handshake on the timeout cycle: the transaction would
                // otherwise be forwarded but never accounted for in DRAIN.
                mst_req_o    = slv_req_i && below_max && !timeout_hit;
                slv_gnt_o    = mst_gnt_i && below_max && !timeout_hit;
                handshake    = mst_req_o && mst_gnt_i;
                slv_rvalid_o = mst_rvalid_i;

                if (handshake && !mst_rvalid_i) begin
                    cnt_d = cnt_q + CntOne;
                end else if (!handshake && mst_rvalid_i && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CntOne;
                end

                if ((cnt_q == '0) || mst_rvalid_i) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + WdOne;
                end

                if (timeout_hit) begin
                    state_d   = ST_DRAIN;
                    stale_d   = clear_i ? '0 : cnt_q;
                    timeout_d = 1'b1;
                    wd_d      = '0;
                end
            end

            ST_DRAIN: begin
                // One local error response per abandoned transaction.
                slv_rvalid_o = 1'b1;
                slv_err_o    = 1'b1;
                slv_rdata_o  = ErrRdata;
                stale_d      = stale_next;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end
                if (cnt_q <= CntOne) begin
                    state_d = (stale_next != '0) ? ST_BLOCKED : ST_ACTIVE;
                end
            end

            ST_BLOCKED: begin
                // Requests are accepted locally and answered with an error on
                // the following cycle; nothing reaches the link.
                slv_gnt_o    = slv_req_i && (stale_q != '0);
                err_pend_d   = slv_gnt_o;
                slv_rvalid_o = err_pend_q;
                slv_err_o    = err_pend_q;
                slv_rdata_o  = ErrRdata;
                stale_d      = stale_next;
                if ((stale_next == '0) && !err_pend_d) begin
                    state_d = ST_ACTIVE;
                end
            end

            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ACTIVE;
            cnt_q      <= '0;
            stale_q    <= '0;
            wd_q       <= '0;
            err_pend_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stale_q    <= stale_d;
            wd_q       <= wd_d;
            err_pend_q <= err_pend_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_serial_link_obi_watchdog.sv
// -----------------------------------------------------------------------------
// tb_serial_link_obi_watchdog
//
// Directed scenarios followed by randomized traffic. A behavioural model keeps
// the outstanding transactions as a queue of addresses, counts silent cycles,
// and tracks the operating mode, abandoned count and owed error responses. Every
// cycle the DUT outputs are compared against the model at the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_link_obi_watchdog;

    localparam int          MAX = 4;
    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hBADCAB1E;
    localparam int          SW  = $clog2(MAX + 1);

    logic          clk_i;
    logic          rst_ni;
    logic          slv_req_i;
    logic          slv_gnt_o;
    logic [31:0]   slv_addr_i;
    logic          slv_we_i;
    logic [3:0]    slv_be_i;
    logic [31:0]   slv_wdata_i;
    logic          slv_rvalid_o;
    logic [31:0]   slv_rdata_o;
    logic          slv_err_o;
    logic          mst_req_o;
    logic          mst_gnt_i;
    logic [31:0]   mst_addr_o;
    logic          mst_we_o;
    logic [3:0]    mst_be_o;
    logic [31:0]   mst_wdata_o;
    logic          mst_rvalid_i;
    logic [31:0]   mst_rdata_i;
    logic          clear_i;
    logic          timeout_o;
    logic          blocked_o;
    logic [SW-1:0] stale_o;

    serial_link_obi_watchdog #(
        .MaxOutstanding (MAX),
        .TimeoutCycles  (TO),
        .ErrRdata       (ERR)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .slv_req_i    (slv_req_i),
        .slv_gnt_o    (slv_gnt_o),
        .slv_addr_i   (slv_addr_i),
        .slv_we_i     (slv_we_i),
        .slv_be_i     (slv_be_i),
        .slv_wdata_i  (slv_wdata_i),
        .slv_rvalid_o (slv_rvalid_o),
        .slv_rdata_o  (slv_rdata_o),
        .slv_err_o    (slv_err_o),
        .mst_req_o    (mst_req_o),
        .mst_gnt_i    (mst_gnt_i),
        .mst_addr_o   (mst_addr_o),
        .mst_we_o     (mst_we_o),
        .mst_be_o     (mst_be_o),
        .mst_wdata_o  (mst_wdata_o),
        .mst_rvalid_i (mst_rvalid_i),
        .mst_rdata_i  (mst_rdata_i),
        .clear_i      (clear_i),
        .timeout_o    (timeout_o),
        .blocked_o    (blocked_o),
        .stale_o      (stale_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_ACT   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_BLK   = 2;

    logic [31:0] exp_q[$];      // addresses of transactions awaiting a link response
    int          m_mode;
    int          m_silent;      // response-less cycles with work outstanding
    int          m_stale;       // abandoned transactions not yet answered by the link
    int          m_drain_left;  // local error responses still owed in DRAIN
    bit          m_err_next;    // a BLOCKED grant owes an error response next cycle
    bit          m_timeout_next;

    // Observations from the most recent checked cycle.
    bit          obs_gnt, obs_req, obs_rvalid, obs_err, obs_timeout, obs_blocked;
    logic [31:0] obs_rdata;
    int          obs_stale;
    int          n_grants, n_errrsp;

    task automatic model_reset();
        exp_q.delete();
        m_mode         = M_ACT;
        m_silent       = 0;
        m_stale        = 0;
        m_drain_left   = 0;
        m_err_next     = 1'b0;
        m_timeout_next = 1'b0;
    endtask

    // Called at the falling edge: inputs are stable, outputs have settled.
    task automatic eval_cycle();
        bit          e_req, e_gnt, e_rv, e_err, fire;
        logic [31:0] e_rdata;
        int          n;
        n       = exp_q.size();
        e_req   = 1'b0;
        e_gnt   = 1'b0;
        e_rv    = 1'b0;
        e_err   = 1'b0;
        fire    = 1'b0;
        e_rdata = mst_rdata_i;
        case (m_mode)
            M_ACT: begin
                fire  = (n > 0) && (m_silent == TO - 1) && !mst_rvalid_i;
                e_req = slv_req_i && (n < MAX) && !fire;
                e_gnt = mst_gnt_i && (n < MAX) && !fire;
                e_rv  = mst_rvalid_i;
            end
            M_DRAIN: begin
                e_rv    = 1'b1;
                e_err   = 1'b1;
                e_rdata = ERR;
            end
            default: begin
                e_gnt   = slv_req_i && (m_stale > 0);
                e_rv    = m_err_next;
                e_err   = m_err_next;
                e_rdata = ERR;
            end
        endcase

        check_val("mst_req", 32'(mst_req_o), 32'(e_req));
        check_val("slv_gnt", 32'(slv_gnt_o), 32'(e_gnt));
        check_val("slv_rvalid", 32'(slv_rvalid_o), 32'(e_rv));
        check_val("slv_err", 32'(slv_err_o), 32'(e_err));
        if (e_rv) check_val("slv_rdata", slv_rdata_o, e_rdata);
        check_val("timeout", 32'(timeout_o), 32'(m_timeout_next));
        check_val("blocked", 32'(blocked_o), 32'(m_mode != M_ACT));
        check_val("stale", 32'(stale_o), 32'(m_stale));
        check_val("mst_addr", mst_addr_o, slv_addr_i);
        check_val("mst_wdata", mst_wdata_o, slv_wdata_i);
        check_val("mst_ctl", {27'd0, mst_we_o, mst_be_o}, {27'd0, slv_we_i, slv_be_i});

        obs_gnt     = slv_gnt_o;
        obs_req     = mst_req_o;
        obs_rvalid  = slv_rvalid_o;
        obs_err     = slv_err_o;
        obs_rdata   = slv_rdata_o;
        obs_timeout = timeout_o;
        obs_blocked = blocked_o;
        obs_stale   = int'(stale_o);
        if (slv_gnt_o) n_grants++;
        if (slv_rvalid_o && slv_err_o) n_errrsp++;

        // Advance the model to the next cycle.
        m_timeout_next = fire;
        case (m_mode)
            M_ACT: begin
                if (e_req && mst_gnt_i) exp_q.push_back(slv_addr_i);
                if (mst_rvalid_i && exp_q.size() > 0) void'(exp_q.pop_front());
                m_silent = (n == 0 || mst_rvalid_i) ? 0 : m_silent + 1;
                if (fire) begin
                    m_mode       = M_DRAIN;
                    m_drain_left = n;
                    m_stale      = n;
                    m_silent     = 0;
                    exp_q.delete();
                end
                if (clear_i) m_stale = 0;
            end
            M_DRAIN: begin
                m_drain_left--;
                if (mst_rvalid_i && m_stale > 0) m_stale--;
                if (clear_i) m_stale = 0;
                if (m_drain_left == 0) m_mode = (m_stale > 0) ? M_BLK : M_ACT;
            end
            default: begin
                if (mst_rvalid_i && m_stale > 0) m_stale--;
                if (clear_i) m_stale = 0;
                m_err_next = e_gnt;
                if (m_stale == 0 && !m_err_next) m_mode = M_ACT;
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk_i);
        eval_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        slv_req_i    = 1'b0;
        slv_addr_i   = '0;
        slv_we_i     = 1'b0;
        slv_be_i     = 4'hF;
        slv_wdata_i  = '0;
        mst_gnt_i    = 1'b0;
        mst_rvalid_i = 1'b0;
        mst_rdata_i  = '0;
        clear_i      = 1'b0;
    endtask

    task automatic issue(input int k);
        for (int i = 0; i < k; i++) begin
            set_idle();
            slv_req_i  = 1'b1;
            slv_addr_i = $urandom;
            mst_gnt_i  = 1'b1;
            step();
        end
        set_idle();
    endtask

    // Issue k transactions, stay silent until the block has drained into BLOCKED.
    task automatic force_blocked(input int k, input string tag);
        bit reached;
        reached = 1'b0;
        issue(k);
        for (int i = 0; i < 3 * TO && !reached; i++) begin
            step();
            reached = (m_mode == M_BLK);
        end
        check_val({tag, "_reach"}, 32'(reached), 32'd1);
        step();
        check_val({tag, "_blk"}, 32'(obs_blocked), 32'd1);
        check_val({tag, "_stale"}, 32'(obs_stale), 32'(k));
    endtask

    task automatic drive_random(input int rv_pct);
        slv_req_i   = 1'($urandom_range(0, 1));
        slv_addr_i  = $urandom;
        slv_we_i    = 1'($urandom_range(0, 1));
        slv_be_i    = 4'($urandom);
        slv_wdata_i = $urandom;
        mst_gnt_i   = ($urandom_range(0, 99) < 70);
        if (m_mode == M_ACT)
            mst_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 99) < rv_pct);
        else
            mst_rvalid_i = ($urandom_range(0, 99) < 15);
        mst_rdata_i = $urandom;
        clear_i     = ($urandom_range(0, 99) < 2);
    endtask

    // ---------------- run bound ----------------
    initial begin
        #1_000_000;
        $display("FAIL run_bound simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        bit seen;
        set_idle();
        model_reset();
        n_grants = 0;
        n_errrsp = 0;

        // Reset values while reset is held.
        rst_ni = 1'b0;
        #12;
        check_val("rst_mst_req", 32'(mst_req_o), 32'd0);
        check_val("rst_slv_gnt", 32'(slv_gnt_o), 32'd0);
        check_val("rst_rvalid", 32'(slv_rvalid_o), 32'd0);
        check_val("rst_err", 32'(slv_err_o), 32'd0);
        check_val("rst_timeout", 32'(timeout_o), 32'd0);
        check_val("rst_blocked", 32'(blocked_o), 32'd0);
        check_val("rst_stale", 32'(stale_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();

        // Forwarding: read at 0x1000, response three cycles after the grant.
        set_idle();
        slv_req_i  = 1'b1;
        slv_addr_i = 32'h0000_1000;
        mst_gnt_i  = 1'b1;
        step();
        check_val("fwd_gnt", 32'(obs_gnt), 32'd1);
        set_idle();
        step();
        step();
        mst_rvalid_i = 1'b1;
        mst_rdata_i  = 32'hCAFE_0001;
        step();
        check_val("fwd_rvalid", 32'(obs_rvalid), 32'd1);
        check_val("fwd_rdata", obs_rdata, 32'hCAFE_0001);
        check_val("fwd_err", 32'(obs_err), 32'd0);
        set_idle();
        step();

        // Outstanding limit: five requests, only four granted.
        n_grants = 0;
        set_idle();
        slv_req_i = 1'b1;
        mst_gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            slv_addr_i = $urandom;
            step();
        end
        check_val("lim_grants", 32'(n_grants), 32'd4);
        check_val("lim_gnt5", 32'(obs_gnt), 32'd0);
        check_val("lim_req5", 32'(obs_req), 32'd0);
        mst_rvalid_i = 1'b1;
        step();
        mst_rvalid_i = 1'b0;
        step();
        check_val("lim_grant_after_rsp", 32'(n_grants), 32'd5);
        set_idle();
        for (int i = 0; i < 4; i++) begin
            mst_rvalid_i = 1'b1;
            mst_rdata_i  = $urandom;
            step();
        end
        set_idle();
        step();

        // Timeout with two outstanding.
        issue(2);
        n_errrsp = 0;
        seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 3 * TO && !seen; i++) begin
            step();
            if (obs_timeout) begin
                seen = 1'b1;
                k = i;
            end
        end
        check_val("to_seen", 32'(seen), 32'd1);
        check_val("to_latency", 32'(k), 32'(TO));
        step();
        step();
        check_val("to_errrsp", 32'(n_errrsp), 32'd2);
        check_val("to_blocked", 32'(obs_blocked), 32'd1);
        check_val("to_stale", 32'(obs_stale), 32'd2);

        // Late responses are swallowed, then normal forwarding resumes.
        mst_rvalid_i = 1'b1;
        mst_rdata_i  = 32'h1111_1111;
        step();
        check_val("late1_rvalid", 32'(obs_rvalid), 32'd0);
        step();
        check_val("late2_rvalid", 32'(obs_rvalid), 32'd0);
        set_idle();
        step();
        check_val("late_unblocked", 32'(obs_blocked), 32'd0);
        check_val("late_stale", 32'(obs_stale), 32'd0);
        issue(1);
        mst_rvalid_i = 1'b1;
        mst_rdata_i  = 32'h2222_3333;
        step();
        check_val("late_fwd_rdata", obs_rdata, 32'h2222_3333);
        set_idle();
        step();

        // Fast fail in BLOCKED.
        force_blocked(2, "ff");
        n_grants = 0;
        n_errrsp = 0;
        slv_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slv_addr_i = $urandom;
            step();
        end
        set_idle();
        step();
        check_val("ff_grants", 32'(n_grants), 32'd3);
        check_val("ff_errrsp", 32'(n_errrsp), 32'd3);

        // clear_i in BLOCKED returns to ACTIVE.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        step();
        check_val("clr_blocked", 32'(obs_blocked), 32'd0);
        check_val("clr_stale", 32'(obs_stale), 32'd0);

        // Reset in the middle of DRAIN.
        issue(4);
        seen = 1'b0;
        for (int i = 0; i < 3 * TO && !seen; i++) begin
            step();
            seen = obs_timeout;
        end
        check_val("rd_seen", 32'(seen), 32'd1);
        set_idle();
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("rd_mst_req", 32'(mst_req_o), 32'd0);
        check_val("rd_slv_gnt", 32'(slv_gnt_o), 32'd0);
        check_val("rd_rvalid", 32'(slv_rvalid_o), 32'd0);
        check_val("rd_err", 32'(slv_err_o), 32'd0);
        check_val("rd_timeout", 32'(timeout_o), 32'd0);
        check_val("rd_blocked", 32'(blocked_o), 32'd0);
        check_val("rd_stale", 32'(stale_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();

        // Randomized traffic, alternating chatty and near-silent link phases.
        for (int i = 0; i < 3000; i++) begin
            drive_random(((i / 500) % 2 == 0) ? 40 : 4);
            step();
        end
        set_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
